// File: rtl/mode_counter.sv
// Multi-mode counter: binary up/down, Gray up and Johnson ring, with enable,
// synchronous parallel load and a combinational terminal-count flag for cascading.
module mode_counter #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] Q,
    output logic             TC
);

    typedef enum logic [1:0] {
        BIN_UP   = 2'b00,
        BIN_DOWN = 2'b01,
        GRAY_UP  = 2'b10,
        JOHNSON  = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] JOHNSON_LAST = {1'b1, {(WIDTH-1){1'b0}}};

    mode_t            mode;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_next;
    logic             terminal;

    assign mode = mode_t'(MODE);

    // Out-of-range states count as terminal so the next enabled edge pulls them back.
    always_comb begin
        terminal = 1'b0;
        s_next   = s;
        case (mode)
            BIN_UP, GRAY_UP: begin
                terminal = (s >= MAX);
                s_next   = terminal ? '0 : s + ONE;
            end
            BIN_DOWN: begin
                terminal = (s == '0) || (s > MAX);
                s_next   = terminal ? MAX : s - ONE;
            end
            JOHNSON: begin
                terminal = (s == JOHNSON_LAST);
                s_next   = {s[WIDTH-2:0], ~s[WIDTH-1]};
            end
            default: begin
                terminal = 1'b0;
                s_next   = s;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            s <= '0;
        end else if (LOAD) begin
            s <= D;
        end else if (EN) begin
            s <= s_next;
        end
    end

    // In Gray mode the register holds the binary count; the output is its Gray image.
    assign Q  = (mode == GRAY_UP) ? (s ^ (s >> 1)) : s;
    assign TC = EN & ~LOAD & ~CLR & terminal;

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter: two instances (MAX=9 and MAX=15) checked every cycle
// against an arithmetic model, plus directed literal expectations.
module tb_mode_counter;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       EN = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] D = 4'd0;
    logic [1:0] MODE = 2'b00;
    logic [3:0] q9, q15;
    logic       tc9, tc15;

    int total = 0;
    int bad = 0;
    bit started = 0;

    int m9 = 0;
    int m15 = 0;

    mode_counter #(.WIDTH(4), .MAX(4'd9)) u9 (
        .CLK(CLK), .CLR(CLR), .EN(EN), .LOAD(LOAD), .D(D), .MODE(MODE), .Q(q9), .TC(tc9)
    );

    mode_counter #(.WIDTH(4), .MAX(4'd15)) u15 (
        .CLK(CLK), .CLR(CLR), .EN(EN), .LOAD(LOAD), .D(D), .MODE(MODE), .Q(q15), .TC(tc15)
    );

    always #5 CLK = ~CLK;

    function automatic int nxt(input int s, input int mode, input int max);
        case (mode)
            0, 2:    return (s >= max) ? 0 : s + 1;
            1:       return (s == 0 || s > max) ? max : s - 1;
            default: return ((s * 2) + (((s / 8) % 2 == 1) ? 0 : 1)) % 16;
        endcase
    endfunction

    function automatic int term(input int s, input int mode, input int max);
        case (mode)
            0, 2:    return (s >= max) ? 1 : 0;
            1:       return (s == 0 || s > max) ? 1 : 0;
            default: return (s == 8) ? 1 : 0;
        endcase
    endfunction

    function automatic int out_of(input int s, input int mode);
        return (mode == 2) ? (s ^ (s / 2)) : s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            m9  <= 0;
            m15 <= 0;
        end else if (LOAD) begin
            m9  <= int'(D);
            m15 <= int'(D);
        end else if (EN) begin
            m9  <= nxt(m9, int'(MODE), 9);
            m15 <= nxt(m15, int'(MODE), 15);
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            check("model_q9", int'(q9), out_of(m9, int'(MODE)));
            check("model_q15", int'(q15), out_of(m15, int'(MODE)));
            check("model_tc9", int'(tc9),
                  (EN && !LOAD && !CLR) ? term(m9, int'(MODE), 9) : 0);
            check("model_tc15", int'(tc15),
                  (EN && !LOAD && !CLR) ? term(m15, int'(MODE), 15) : 0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_pulse();
        CLR = 1'b1;
        #1;
        CLR = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_dec[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int exp_down[6]  = '{3, 2, 1, 0, 9, 8};
        int exp_gray[16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                             4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                             4'b1011, 4'b1001, 4'b1000, 4'b0000};
        int exp_john[9]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                             4'b1100, 4'b1000, 4'b0000, 4'b0001};
        logic [3:0] prev;

        #1 CLR = 1'b1;
        #1 started = 1;
        check("reset_q", int'(q9), 0);
        check("reset_tc", int'(tc9), 0);
        tick();
        CLR  = 1'b0;
        EN   = 1'b1;
        MODE = 2'b00;

        // Reset mid-count
        for (int i = 0; i < 5; i++) tick();
        check("count_to_5", int'(q9), 5);
        #1 CLR = 1'b1;
        #1;
        check("clr_immediate_q", int'(q9), 0);
        check("clr_immediate_tc", int'(tc9), 0);
        tick();
        tick();
        check("clr_hold_q", int'(q9), 0);
        CLR = 1'b0;
        tick();
        check("after_clr_q", int'(q9), 1);

        // Decade up
        clear_pulse();
        for (int i = 0; i < 12; i++) begin
            tick();
            check("decade_q", int'(q9), exp_dec[i]);
            check("decade_tc", int'(tc9), (exp_dec[i] == 9) ? 1 : 0);
        end

        // Down with load
        MODE = 2'b01;
        LOAD = 1'b1;
        D    = 4'd3;
        tick();
        LOAD = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            #1;
            check("down_q", int'(q9), exp_down[i]);
            check("down_tc", int'(tc9), (exp_down[i] == 0) ? 1 : 0);
        end
        LOAD = 1'b1;
        D    = 4'd14;
        tick();
        LOAD = 1'b0;
        #1;
        check("down_oor_q", int'(q9), 14);
        check("down_oor_tc", int'(tc9), 1);
        tick();
        check("down_oor_recover", int'(q9), 9);

        // Gray up over the full 4-bit range
        MODE = 2'b10;
        clear_pulse();
        #1;
        check("gray_start", int'(q15), 0);
        prev = q15;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("gray_q", int'(q15), exp_gray[i]);
            check("gray_onebit", $countones(prev ^ q15), 1);
            check("gray_tc", int'(tc15), (exp_gray[i] == 4'b1000) ? 1 : 0);
            prev = q15;
        end

        // Johnson ring
        MODE = 2'b11;
        clear_pulse();
        for (int i = 0; i < 9; i++) begin
            tick();
            check("john_q", int'(q9), exp_john[i]);
            check("john_tc", int'(tc9), (exp_john[i] == 4'b1000) ? 1 : 0);
        end

        // Enable and load priority
        MODE = 2'b00;
        clear_pulse();
        for (int i = 0; i < 9; i++) tick();
        check("pri_at9_q", int'(q9), 9);
        EN = 1'b0;
        #1;
        check("en_low_tc", int'(tc9), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_low_hold_q", int'(q9), 9);
            check("en_low_hold_tc", int'(tc9), 0);
        end
        EN = 1'b1;
        #1;
        check("en_high_tc", int'(tc9), 1);
        LOAD = 1'b1;
        D    = 4'd7;
        #1;
        check("load_en_tc", int'(tc9), 0);
        tick();
        LOAD = 1'b0;
        check("load_wins_q", int'(q9), 7);
        tick();
        check("after_load_q", int'(q9), 8);

        // Up-mode out-of-range load wraps to zero
        LOAD = 1'b1;
        D    = 4'd14;
        tick();
        LOAD = 1'b0;
        #1;
        check("up_oor_q", int'(q9), 14);
        check("up_oor_tc", int'(tc9), 1);
        tick();
        check("up_oor_wrap", int'(q9), 0);

        @(posedge CLK);
        #2;
        started = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised, multi-mode synchronous counter that generalises the lab's 4-bit schematic counter. It adds a configurable width and modulus, four runtime-selectable count modes (binary up, binary down, Gray up, Johnson), count enable, synchronous parallel load and a terminal-count flag for cascading. It is the standard counter primitive for later labs: a timebase divider, a sequencer step counter, or a cascaded multi-digit counter.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..32.
- MAX, 2**WIDTH-1: terminal value for binary and Gray modes; legal range 1..2**WIDTH-1.
- CLK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  reset, asynchronous, active-high; clears all state immediately.
- EN  in  1  count enable; when low and LOAD is low, the state holds.
- LOAD  in  1  synchronous parallel load; has priority over EN.
- D  in  WIDTH  load value, written raw into the state register S.
- MODE  in  2  count mode: 00 binary up, 01 binary down, 10 Gray up, 11 Johnson.
- Q  out  WIDTH  counter output.
- TC  out  1  terminal count: high when the next enabled edge wraps the counter.

## Operation
- Single state register S[WIDTH-1:0]. Output Q = S in modes 00, 01 and 11. In mode 10, Q = S ^ (S >> 1), so S is the internal binary count.
- Per-edge priority: LOAD, then EN, then hold.
  - LOAD=1: S <= D.
  - LOAD=0, EN=1: S <= next(S, MODE).
  - Otherwise S holds.
- next() by mode:
  - 00 and 10: if S >= MAX, S <= 0; else S <= S+1.
  - 01: if S == 0 or S > MAX, S <= MAX; else S <= S-1.
  - 11: S <= {S[WIDTH-2:0], ~S[WIDTH-1]}. This is a 2*WIDTH-state Johnson ring; MAX is ignored.
- Terminal state T(S, MODE):
  - 00 and 10: S >= MAX.
  - 01: S == 0 or S > MAX.
  - 11: S == {1'b1, {WIDTH-1{1'b0}}}.
- TC = EN & ~LOAD & ~CLR & T(S, MODE). TC is combinational from registered state and inputs, which allows ripple-enable cascading: the TC of a low digit drives the EN of the next digit.
- Out-of-range state, from LOAD of D > MAX or from a mode change: the next enabled count in a binary or Gray mode returns the state to the legal range as defined by next(). It never counts past MAX.
- Illegal Johnson patterns, from LOAD or a mode change: shift per the rule above without correction. Software must load a legal pattern.
- MODE changes take effect at the next edge. S is not reset on a mode change; the count continues from the raw S.

## Timing
- CLR asserted: S = 0, Q = 0 and TC = 0 immediately, with no clock needed. They stay so while CLR is high. The first count edge after CLR deasserts moves S from 0 to next(0).
- CLR asserted mid-count or mid-load: the state is cleared regardless of LOAD and EN, and no partial update occurs.
- Latency: Q reflects a LOAD or count one edge after the inputs are sampled. TC reflects the current S and inputs within the same cycle, with zero latency.
- Wrap: TC is high during the cycle whose rising edge performs the wrap, and low in the following cycle unless the state is still terminal.
- LOAD and EN both high: the load wins, and TC is 0 in that cycle.
- EN low: Q and S hold indefinitely, and TC = 0.
- Reset values: Q = 0, TC = 0. All outputs are defined at time 0 once CLR has been pulsed.

## Test plan
- Reset: WIDTH=4, MAX=9, MODE=00, EN=1. Count to 5, then pulse CLR between clock edges -> Q=0 at once, holds at 0 while CLR is high, and is 1 after the first edge after release.
- Decade up: MODE=00, MAX=9, EN=1 for 12 edges -> Q sequence 1..9,0,1,2; TC high only while Q=9.
- Down with load: MODE=01, MAX=9. LOAD with D=3, then count -> Q sequence 3,2,1,0,9,8; TC high only while Q=0. LOAD with D=14, then count -> Q=9.
- Gray: WIDTH=4, MAX=15, MODE=10, 16 edges from reset -> Q sequence 0001,0011,0010,0110,…,1000,0000. Exactly one Q bit changes per edge; TC is high only while Q=1000.
- Johnson: WIDTH=4, MODE=11, 9 edges from reset -> Q sequence 0001,0011,0111,1111,1110,1100,1000,0000,0001; TC is high only while Q=1000.
- Enable and priority: hold EN=0 for 3 edges -> Q is unchanged and TC=0. Drive LOAD=1 and EN=1 with D=7 in the cycle where Q=9 (MODE=00) -> Q=7, TC=0 in that cycle, and no wrap occurs.
